// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer.
// States, opcodes, datapath select codes and the control bundle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_HALT      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// State-to-controls table for the multi-cycle sequencer.
// Only FETCH looks at mem_ready, to gate the IR and PC loads.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
            end
            S_ADDI_WB: ctrl.reg_write = 1'b1;
            S_HALT:    ctrl.halted    = 1'b1;
            default:   ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WB,
// traps illegal opcodes and counts retired instructions.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IorD,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic [1:0]      PCSource,
    output logic [1:0]      ALUOp,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            MemtoReg,
    output logic            halted,
    output logic [3:0]      state,
    output logic [CNTW-1:0] retired
);

    state_t          state_q;
    state_t          state_d;
    logic            retire;
    logic [CNTW-1:0] retired_q;
    logic [5:0]      op;
    ctrl_t           ctrl;

    // The branch outcome is resolved in the datapath via PCWriteCond.
    logic unused_zero;
    assign unused_zero = zero;

    assign op = 6'(opcode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                retired_q <= retired_q + CNTW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_IDLE:
                if (run) state_d = S_FETCH;
            S_FETCH:
                if (mem_ready) state_d = S_DECODE;
            S_DECODE:
                case (op)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_HALT;
                endcase
            S_MEM_ADDR:
                case (op)
                    OP_LW:   state_d = S_MEM_READ;
                    OP_SW:   state_d = S_MEM_WRITE;
                    default: state_d = S_HALT;
                endcase
            S_MEM_READ:
                if (mem_ready) state_d = S_MEM_WB;
            S_R_EXEC:    state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB,
            S_MEM_WRITE: begin
                // A store completes on its mem_ready cycle.
                if (state_q != S_MEM_WRITE || mem_ready) begin
                    retire  = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign mem_req     = ctrl.mem_req;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IorD        = ctrl.iord;
    assign IRWrite     = ctrl.ir_write;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCSource    = ctrl.pc_source;
    assign ALUOp       = ctrl.alu_op;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign halted      = ctrl.halted;
    assign state       = state_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase lists and a
// control table drive a cycle-accurate reference of every output.
module tb_multicycle_control;

    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic [5:0]      opcode;
    logic            zero;
    logic            mem_ready;
    logic            mem_req, MemRead, MemWrite, IorD, IRWrite;
    logic            PCWrite, PCWriteCond, ALUSrcA;
    logic            RegDst, RegWrite, MemtoReg, halted;
    logic [1:0]      PCSource, ALUOp, ALUSrcB;
    logic [3:0]      state;
    logic [CNTW-1:0] retired;

    int passed = 0;
    int total  = 0;
    int exp_ret = 0;
    int zero_mode = 2;
    int mw_cnt, rw_cnt, pcwc_cnt;

    multicycle_control #(.OPW(6), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .halted(halted),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] obs_ctrl();
        return {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite,
                PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB,
                RegDst, RegWrite, MemtoReg, halted};
    endfunction

    // Expected controls for a phase, written straight from the state table.
    function automatic logic [17:0] exp_ctrl(int ph, logic mr);
        logic       req, rd, wr, iord, irw, pcw, pcwc, sa, dst, rw, m2r, hlt;
        logic [1:0] pcs, aop, sb;
        {req, rd, wr, iord, irw, pcw, pcwc, sa, dst, rw, m2r, hlt} = '0;
        {pcs, aop, sb} = '0;
        case (ph)
            1:  begin req = 1; rd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            2:  sb = 2'b11;
            3:  begin sa = 1; sb = 2'b10; end
            4:  begin req = 1; rd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin req = 1; wr = 1; iord = 1; end
            7:  begin sa = 1; aop = 2'b10; end
            8:  begin rw = 1; dst = 1; end
            9:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin sa = 1; sb = 2'b10; end
            12: rw = 1;
            13: hlt = 1;
            default: ;
        endcase
        return {req, rd, wr, iord, irw, pcw, pcwc, pcs, aop, sa, sb,
                dst, rw, m2r, hlt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, o, e);
    endtask

    // Runs one instruction from FETCH. fs/ms: forced stall cycles in the
    // fetch / memory wait phases; -1 picks them at random.
    task automatic run_instr(input logic [5:0] op, input int fs,
                             input int ms, output int cyc);
        int  path[$];
        int  ph, k, lim;
        logic mr;
        case (op)
            6'h23:   path = '{1, 2, 3, 4, 5};
            6'h2B:   path = '{1, 2, 3, 6};
            6'h00:   path = '{1, 2, 7, 8};
            6'h04:   path = '{1, 2, 9};
            6'h02:   path = '{1, 2, 10};
            6'h08:   path = '{1, 2, 11, 12};
            default: path = '{1, 2, 13};
        endcase
        cyc = 0;
        foreach (path[i]) begin
            ph  = path[i];
            k   = 0;
            lim = (ph == 1) ? fs : ms;
            do begin
                if (lim < 0)
                    mr = (k >= 4) || ($urandom_range(99) < 65);
                else
                    mr = (k >= lim);
                if (ph != 1 && ph != 4 && ph != 6 && $urandom_range(1) == 0)
                    mr = 1'b0;
                mem_ready = mr;
                opcode    = op;
                zero      = (zero_mode == 2) ? 1'($urandom) : 1'(zero_mode);
                #1;
                chk($sformatf("state_c%0d", cyc), 32'(state), 32'(ph));
                chk($sformatf("ctrl_s%0d", ph), 32'(obs_ctrl()),
                    32'(exp_ctrl(ph, mr)));
                if (MemWrite)    mw_cnt++;
                if (RegWrite)    rw_cnt++;
                if (PCWriteCond) pcwc_cnt++;
                @(negedge clk);
                cyc++;
                k++;
            end while ((ph == 1 || ph == 4 || ph == 6) && !mr);
        end
        #1;
        if (path[path.size()-1] == 13) begin
            chk("halt_state", 32'(state), 32'd13);
        end else begin
            exp_ret = (exp_ret + 1) % (1 << CNTW);
            chk("next_state", 32'(state), run ? 32'd1 : 32'd0);
        end
        chk("retired", 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        int       cyc;
        logic [5:0] legal [6];
        legal = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h02, 6'h08};
        rst = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        mw_cnt = 0; rw_cnt = 0; pcwc_cnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctrl", 32'(obs_ctrl()), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);

        run = 1'b1; rst = 1'b1;
        @(negedge clk);
        chk("wake_fetch", 32'(state), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_ctrl", 32'(obs_ctrl()), 32'd0);
        chk("abort_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_instr(6'h02, 0, 0, cyc);
        chk("j_cycles", 32'(cyc), 32'd3);
        run_instr(6'h00, 0, 0, cyc);
        chk("add_cycles", 32'(cyc), 32'd4);
        chk("j_add_retired", 32'(retired), 32'd2);

        run_instr(6'h23, 0, 0, cyc);
        chk("lw_cycles", 32'(cyc), 32'd5);

        mw_cnt = 0; rw_cnt = 0;
        run_instr(6'h2B, 0, 3, cyc);
        chk("sw_cycles", 32'(cyc), 32'd7);
        chk("sw_memwrite", 32'(mw_cnt), 32'd4);
        chk("sw_regwrite", 32'(rw_cnt), 32'd0);

        zero_mode = 1; pcwc_cnt = 0;
        run_instr(6'h04, 0, 0, cyc);
        chk("beq1_cycles", 32'(cyc), 32'd3);
        chk("beq1_pcwc", 32'(pcwc_cnt), 32'd1);
        zero_mode = 0; pcwc_cnt = 0;
        run_instr(6'h04, 0, 0, cyc);
        chk("beq0_cycles", 32'(cyc), 32'd3);
        chk("beq0_pcwc", 32'(pcwc_cnt), 32'd1);
        zero_mode = 2;

        run_instr(6'h08, 2, 0, cyc);
        chk("addi_cycles", 32'(cyc), 32'd6);

        run = 1'b0;
        run_instr(6'h23, 1, 2, cyc);
        chk("park_cycles", 32'(cyc), 32'd8);
        @(negedge clk);
        chk("park_idle", 32'(state), 32'd0);
        chk("park_ctrl", 32'(obs_ctrl()), 32'd0);
        run = 1'b1;
        @(negedge clk);
        chk("unpark", 32'(state), 32'd1);

        for (int n = 0; n < 40; n++)
            run_instr(legal[$urandom_range(5)], -1, -1, cyc);

        run_instr(6'h3F, 0, 0, cyc);
        chk("halted_flag", 32'(halted), 32'd1);
        for (int n = 0; n < 6; n++) begin
            run = 1'($urandom);
            mem_ready = 1'($urandom);
            @(negedge clk);
            #1;
            chk("halt_sticky", 32'(state), 32'd13);
            chk("halt_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(13, 1'b0)));
            chk("halt_retired", 32'(retired), 32'(exp_ret));
        end
        rst = 1'b0;
        #1;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_halted", 32'(halted), 32'd0);
        chk("clr_retired", 32'(retired), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
